// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, ALU, NZCV flags, condition unit,
// iterative shift-add multiplier with stall handshake, and EX/MEM register.
module execute_stage_mc #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              validE,
  input  logic              FlushE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemToRegE,
  input  logic              PCSrcE,
  input  logic              BranchE,
  input  logic              FlagWriteE,
  input  logic              ALUSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [3:0]        CondE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] dataRegAIn,
  input  logic [DATA_W-1:0] dataRegBIn,
  input  logic [DATA_W-1:0] extIn,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [REG_AW-1:0] WA3E,
  output logic              StallE,
  output logic              BranchTakenE,
  output logic [3:0]        flagsEout,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_AW-1:0] WA3M,
  output logic              validM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemToRegM,
  output logic              PCSrcM
);

  localparam int unsigned N         = DATA_W / MUL_BITS;
  localparam int unsigned CNT_W     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAST_BUSY = (N > 1) ? N - 2 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BUSY);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_EOR = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_MVN = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d, mulb_q, mulb_d, acc_q, acc_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   alu_result_q, alu_result_d, write_data_q, write_data_d;
  logic [REG_AW-1:0]   wa3_q, wa3_d;
  logic                valid_q, valid_d, reg_write_q, reg_write_d;
  logic                mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic                pc_src_q, pc_src_d;

  logic [DATA_W-1:0]   src_a, write_data, src_b, result;
  logic [DATA_W:0]     sum;
  logic                cond_ex, mul_go, start_c, step_c;
  logic                c_new, v_new, upd_nz, upd_cv;

  // Partial product of the multiplicand with one MUL_BITS-wide digit of B.
  function automatic logic [DATA_W-1:0] partial(input logic [DATA_W-1:0] mc,
                                                input logic [MUL_BITS-1:0] dig);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int j = 0; j < int'(MUL_BITS); j++) begin
      if (dig[j]) s = s + (mc << j);
    end
    return s;
  endfunction

  // Operand forwarding muxes and immediate select.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = dataRegAIn;
    endcase
    case (ForwardBE)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = alu_result_q;
      default: write_data = dataRegBIn;
    endcase
    src_b = ALUSrcE ? extIn : write_data;
  end

  // ARM condition evaluation on the architectural flag register {N,Z,C,V}.
  always_comb begin
    case (CondE)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign mul_go = validE & cond_ex & ~FlushE & ~reset & (ALUControlE == OP_MUL);

  // Multiplier FSM state register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Multiplier FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mul_go) state_d = (N > 1) ? S_BUSY : S_DONE;
      S_BUSY: begin
        if (FlushE)                 state_d = S_IDLE;
        else if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier FSM outputs: stall while the start cycle and BUSY are in progress.
  always_comb begin
    StallE  = 1'b0;
    start_c = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_c = mul_go;
        StallE  = mul_go;
      end
      S_BUSY: begin
        StallE = 1'b1;
        step_c = ~FlushE;
      end
      default: ;
    endcase
  end

  // Shift-add datapath; the first digit is retired on the start edge so the
  // stall lasts exactly N cycles.
  always_comb begin
    mcand_d = mcand_q;
    mulb_d  = mulb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (start_c) begin
      acc_d   = partial(src_a, src_b[MUL_BITS-1:0]);
      mcand_d = src_a << MUL_BITS;
      mulb_d  = src_b >> MUL_BITS;
      cnt_d   = '0;
    end else if (step_c) begin
      acc_d   = acc_q + partial(mcand_q, mulb_q[MUL_BITS-1:0]);
      mcand_d = mcand_q << MUL_BITS;
      mulb_d  = mulb_q >> MUL_BITS;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // ALU result and candidate flag values.
  always_comb begin
    sum    = '0;
    result = '0;
    c_new  = flags_q[1];
    v_new  = flags_q[0];
    upd_nz = 1'b0;
    upd_cv = 1'b0;
    case (ALUControlE)
      OP_ADD: begin
        sum    = {1'b0, src_a} + {1'b0, src_b};
        result = sum[DATA_W-1:0];
        c_new  = sum[DATA_W];
        v_new  = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (result[DATA_W-1] != src_a[DATA_W-1]);
        upd_nz = 1'b1;
        upd_cv = 1'b1;
      end
      OP_SUB: begin
        sum    = {1'b0, src_a} + {1'b0, ~src_b} + (DATA_W+1)'(1);
        result = sum[DATA_W-1:0];
        c_new  = sum[DATA_W];
        v_new  = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (result[DATA_W-1] != src_a[DATA_W-1]);
        upd_nz = 1'b1;
        upd_cv = 1'b1;
      end
      OP_AND: begin result = src_a & src_b; upd_nz = 1'b1; end
      OP_ORR: begin result = src_a | src_b; upd_nz = 1'b1; end
      OP_EOR: begin result = src_a ^ src_b; upd_nz = 1'b1; end
      OP_MOV: begin result = src_b;         upd_nz = 1'b1; end
      OP_MVN: begin result = ~src_b;        upd_nz = 1'b1; end
      OP_MUL: begin
        result = (state_q == S_DONE) ? acc_q : '0;
        upd_nz = 1'b1;
      end
      default: ;
    endcase
  end

  // Flag register update at instruction retire.
  always_comb begin
    flags_d = flags_q;
    if (validE & cond_ex & FlagWriteE & ~FlushE & ~StallE) begin
      if (upd_nz) flags_d[3:2] = {result[DATA_W-1], (result == '0)};
      if (upd_cv) flags_d[1:0] = {c_new, v_new};
    end
  end

  // EX/MEM next value: bubble on stall, flush or empty slot, else load.
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    pc_src_d     = 1'b0;
    if (!(StallE | FlushE | ~validE)) begin
      alu_result_d = result;
      write_data_d = write_data;
      wa3_d        = WA3E;
      valid_d      = 1'b1;
      reg_write_d  = RegWriteE & cond_ex;
      mem_write_d  = MemWriteE & cond_ex;
      mem_to_reg_d = MemToRegE;
      pc_src_d     = PCSrcE & cond_ex;
    end
  end

  // Datapath, flag and EX/MEM registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      mcand_q      <= '0;
      mulb_q       <= '0;
      acc_q        <= '0;
      flags_q      <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      wa3_q        <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_src_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mulb_q       <= mulb_d;
      acc_q        <= acc_d;
      flags_q      <= flags_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_src_q     <= pc_src_d;
    end
  end

  assign BranchTakenE = BranchE & cond_ex & validE & ~StallE;
  assign flagsEout    = flags_q;
  assign ALUResultM   = alu_result_q;
  assign WriteDataM   = write_data_q;
  assign WA3M         = wa3_q;
  assign validM       = valid_q;
  assign RegWriteM    = reg_write_q;
  assign MemWriteM    = mem_write_q;
  assign MemToRegM    = mem_to_reg_q;
  assign PCSrcM       = pc_src_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc with DATA_W=32, MUL_BITS=1.
module tb_execute_stage_mc;

  logic        Clk, reset, validE, FlushE;
  logic        RegWriteE, MemWriteE, MemToRegE, PCSrcE, BranchE, FlagWriteE, ALUSrcE;
  logic [3:0]  ALUControlE, CondE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] dataRegAIn, dataRegBIn, extIn, ResultW;
  logic [3:0]  WA3E;
  logic        StallE, BranchTakenE;
  logic [3:0]  flagsEout;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WA3M;
  logic        validM, RegWriteM, MemWriteM, MemToRegM, PCSrcM;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, bad;

  execute_stage_mc #(.DATA_W(32), .REG_AW(4), .MUL_BITS(1)) dut (
    .Clk(Clk), .reset(reset), .validE(validE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
    .PCSrcE(PCSrcE), .BranchE(BranchE), .FlagWriteE(FlagWriteE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .CondE(CondE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .dataRegAIn(dataRegAIn), .dataRegBIn(dataRegBIn), .extIn(extIn), .ResultW(ResultW),
    .WA3E(WA3E), .StallE(StallE), .BranchTakenE(BranchTakenE), .flagsEout(flagsEout),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M), .validM(validM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .PCSrcM(PCSrcM)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] cond, input logic fw, input logic rw);
    validE = 1'b1; FlushE = 1'b0; ALUControlE = op; CondE = cond;
    dataRegAIn = a; dataRegBIn = b; FlagWriteE = fw; RegWriteE = rw;
    MemWriteE = 1'b0; MemToRegE = 1'b0; PCSrcE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; WA3E = 4'd3;
  endtask

  // Count stall cycles of a MUL; scramble operands once BUSY; every M slot must be a bubble.
  task automatic run_mul(output int stalls, output int bubbles_bad);
    stalls = 0; bubbles_bad = 0;
    while (StallE === 1'b1 && stalls < 100) begin
      stalls++;
      step();
      if (validM !== 1'b0 || RegWriteM !== 1'b0) bubbles_bad++;
      if (stalls == 1) begin dataRegAIn = 32'h1234_5678; dataRegBIn = 32'h0BAD_F00D; end
    end
  endtask

  initial begin
    reset = 1'b0; extIn = 32'h0; ResultW = 32'h0;
    set_op(4'b0000, 32'd0, 32'd0, 4'b1110, 1'b0, 1'b0);
    validE = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_result", ALUResultM, 32'h0);
    check("rst_validM", 32'(validM), 32'h0);
    check("rst_flags",  32'(flagsEout), 32'h0);
    check("rst_stall",  32'(StallE), 32'h0);
    #10 reset = 1'b0;

    // ADD 5+7
    set_op(4'b0000, 32'd5, 32'd7, 4'b1110, 1'b1, 1'b1);
    step();
    check("add_result", ALUResultM, 32'd12);
    check("add_validM", 32'(validM), 32'h1);
    check("add_regw",   32'(RegWriteM), 32'h1);
    check("add_flags",  32'(flagsEout), 32'h0);

    // SUB 3-3 -> Z=1, C=1
    set_op(4'b0001, 32'd3, 32'd3, 4'b1110, 1'b1, 1'b1);
    step();
    check("sub_result", ALUResultM, 32'h0);
    check("sub_flags",  32'(flagsEout), 32'h6);

    // MOVNE with Z set: retires but does not write
    set_op(4'b0101, 32'd0, 32'd9, 4'b0001, 1'b1, 1'b1);
    step();
    check("movne_regw",  32'(RegWriteM), 32'h0);
    check("movne_valid", 32'(validM), 32'h1);
    check("movne_flags", 32'(flagsEout), 32'h6);

    // Signed overflow
    set_op(4'b0000, 32'h7FFF_FFFF, 32'h1, 4'b1110, 1'b1, 1'b1);
    step();
    check("ovf_result", ALUResultM, 32'h8000_0000);
    check("ovf_flags",  32'(flagsEout), 32'h9);

    // AND: N,Z updated, C,V held
    set_op(4'b0010, 32'hF0, 32'h0F, 4'b1110, 1'b1, 1'b1);
    step();
    check("and_result", ALUResultM, 32'h0);
    check("and_flags",  32'(flagsEout), 32'h5);

    // MOV 0x10 under EQ (taken branch) with immediate operand
    set_op(4'b0101, 32'h0, 32'hFFFF, 4'b0000, 1'b0, 1'b1);
    ALUSrcE = 1'b1; extIn = 32'h10; BranchE = 1'b1; PCSrcE = 1'b1;
    #1;
    check("br_taken", 32'(BranchTakenE), 32'h1);
    step();
    check("mov_result", ALUResultM, 32'h10);
    check("mov_pcsrc",  32'(PCSrcM), 32'h1);

    // Forwarded STR address/data
    set_op(4'b0000, 32'h999, 32'h777, 4'b1110, 1'b0, 1'b0);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h20; MemWriteE = 1'b1; WA3E = 4'd9;
    step();
    check("fwd_result", ALUResultM, 32'h30);
    check("fwd_wdata",  WriteDataM, 32'h20);
    check("fwd_memw",   32'(MemWriteM), 32'h1);
    check("fwd_wa3",    32'(WA3M), 32'h9);

    // Undefined op: result 0, flags held
    set_op(4'b0111, 32'd5, 32'd5, 4'b1110, 1'b1, 1'b1);
    step();
    check("undef_result", ALUResultM, 32'h0);
    check("undef_flags",  32'(flagsEout), 32'h5);

    // Condition 1111 never executes
    set_op(4'b0000, 32'd1, 32'd1, 4'b1111, 1'b1, 1'b1);
    BranchE = 1'b1;
    #1;
    check("nv_branch", 32'(BranchTakenE), 32'h0);
    step();
    check("nv_regw",  32'(RegWriteM), 32'h0);
    check("nv_valid", 32'(validM), 32'h1);
    check("nv_result", ALUResultM, 32'h2);

    // Empty slot
    validE = 1'b0;
    step();
    check("bubble_valid", 32'(validM), 32'h0);

    // MUL 6*7
    set_op(4'b1000, 32'd6, 32'd7, 4'b1110, 1'b0, 1'b1);
    #1;
    check("mul1_stall_start", 32'(StallE), 32'h1);
    run_mul(cyc, bad);
    check("mul1_stall_cycles", 32'(cyc), 32'd32);
    check("mul1_bubbles", 32'(bad), 32'h0);
    step();
    check("mul1_result", ALUResultM, 32'd42);
    check("mul1_valid",  32'(validM), 32'h1);
    check("mul1_regw",   32'(RegWriteM), 32'h1);
    check("mul1_flags",  32'(flagsEout), 32'h5);

    // MUL 0xFFFFFFFF*2 with flag write
    set_op(4'b1000, 32'hFFFF_FFFF, 32'd2, 4'b1110, 1'b1, 1'b1);
    #1;
    run_mul(cyc, bad);
    check("mul2_stall_cycles", 32'(cyc), 32'd32);
    step();
    check("mul2_result", ALUResultM, 32'hFFFF_FFFE);
    check("mul2_flags",  32'(flagsEout), 32'h9);

    // Flushed MUL in BUSY cycle 10
    set_op(4'b1000, 32'd6, 32'd7, 4'b1110, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 9; i++) step();
    FlushE = 1'b1;
    #1;
    check("flush_stall_before", 32'(StallE), 32'h1);
    step();
    check("flush_stall_after", 32'(StallE), 32'h0);
    check("flush_valid", 32'(validM), 32'h0);
    check("flush_flags", 32'(flagsEout), 32'h9);
    FlushE = 1'b0; validE = 1'b0;
    step();
    check("flush_no_retire", 32'(validM), 32'h0);
    check("flush_data_held", ALUResultM, 32'hFFFF_FFFE);

    // Reset mid-MUL
    set_op(4'b1000, 32'd6, 32'd7, 4'b1110, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    #1;
    check("rstmul_stall",  32'(StallE), 32'h0);
    check("rstmul_result", ALUResultM, 32'h0);
    check("rstmul_flags",  32'(flagsEout), 32'h0);
    check("rstmul_valid",  32'(validM), 32'h0);
    validE = 1'b0;
    #5 reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
